// File: rtl/game_countdown_timer.sv
// game_countdown_timer
//   Counts a loaded number of whole seconds down to zero on the 60 Hz game
//   clock and flags time-up to the game FSM. The game controller loads,
//   starts, pauses and aborts it; display and sound logic consume
//   seconds_left, warning and time_up_pulse.
//
// Optional feature macro: TIME_BONUS_EN
//   When defined, adds bonus/bonus_value ports that add time (saturating at
//   MAX_SECONDS) while RUNNING or PAUSED.
//
// Ports:
//   clk_game       in   60 Hz game clock
//   reset_n        in   asynchronous active-low reset
//   load           in   pulse: load load_value (saturated), enter IDLE
//   load_value     in   [7:0] seconds to load
//   start          in   pulse: start from IDLE or resume from PAUSED
//   pause          in   pulse: freeze countdown while RUNNING
//   abort          in   pulse: clear to IDLE with zero seconds
//   bonus          in   pulse: add bonus_value seconds (TIME_BONUS_EN only)
//   bonus_value    in   [3:0] seconds to add (TIME_BONUS_EN only)
//   seconds_left   out  [7:0] remaining whole seconds
//   state          out  [1:0] IDLE=0, RUNNING=1, PAUSED=2, EXPIRED=3
//   running        out  state == RUNNING
//   warning        out  low-time indicator while RUNNING/PAUSED
//   time_up        out  level, state == EXPIRED
//   time_up_pulse  out  one-cycle pulse on entry to EXPIRED

module game_countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 60,
  parameter int unsigned MAX_SECONDS   = 99,
  parameter int unsigned WARN_SECONDS  = 10
) (
  input  logic       clk_game,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
`ifdef TIME_BONUS_EN
  input  logic       bonus,
  input  logic [3:0] bonus_value,
`endif
  output logic [7:0] seconds_left,
  output logic [1:0] state,
  output logic       running,
  output logic       warning,
  output logic       time_up,
  output logic       time_up_pulse
);

  localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [7:0] MAX_S  = 8'(MAX_SECONDS);
  localparam logic [8:0] MAX_S9 = 9'(MAX_SECONDS);
  localparam logic [7:0] WARN_S = 8'(WARN_SECONDS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          secs_q, secs_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                pulse_q, pulse_d;

  logic                bonus_act;
  logic [3:0]          bonus_amt;
  logic [7:0]          load_sat;
  logic [7:0]          secs_dec;
  logic                wrap;

`ifdef TIME_BONUS_EN
  assign bonus_act = bonus;
  assign bonus_amt = bonus_value;
`else
  assign bonus_act = 1'b0;
  assign bonus_amt = '0;
`endif

  // Sum is formed 9 bits wide so 255+15 style overflow can never wrap
  // before the MAX_SECONDS clamp.
  function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [3:0] amt);
    logic [8:0] sum9;
    sum9 = {1'b0, base} + {5'b0, amt};
    return (sum9 > MAX_S9) ? MAX_S : sum9[7:0];
  endfunction

  assign load_sat = (load_value > MAX_S) ? MAX_S : load_value;
  assign secs_dec = (secs_q != '0) ? (secs_q - 8'd1) : '0;
  assign wrap     = (tick_q == TICK_LAST);

  always_ff @(posedge clk_game or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      secs_q  <= '0;
      tick_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      secs_q  <= secs_d;
      tick_q  <= tick_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    secs_d  = secs_q;
    tick_d  = tick_q;
    pulse_d = 1'b0;

    if (load) begin
      secs_d  = load_sat;
      tick_d  = '0;
      state_d = S_IDLE;
    end else if (abort) begin
      secs_d  = '0;
      tick_d  = '0;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (secs_q != '0) begin
              state_d = S_RUNNING;
              tick_d  = '0;
            end else begin
              state_d = S_EXPIRED;
              pulse_d = 1'b1;
            end
          end
        end

        S_RUNNING: begin
          if (pause) begin
            // Tick is held so the partial second survives the pause.
            state_d = S_PAUSED;
            if (bonus_act) secs_d = sat_add(secs_q, bonus_amt);
          end else if (wrap) begin
            tick_d = '0;
            secs_d = bonus_act ? sat_add(secs_dec, bonus_amt) : secs_dec;
            if (secs_d == '0) begin
              state_d = S_EXPIRED;
              pulse_d = 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
            if (bonus_act) secs_d = sat_add(secs_q, bonus_amt);
          end
        end

        S_PAUSED: begin
          if (start) state_d = S_RUNNING;
          if (bonus_act) secs_d = sat_add(secs_q, bonus_amt);
        end

        S_EXPIRED: begin
          secs_d = '0;
          tick_d = '0;
        end

        default: begin
          state_d = S_IDLE;
          secs_d  = '0;
          tick_d  = '0;
        end
      endcase
    end
  end

  assign seconds_left  = secs_q;
  assign state         = state_q;
  assign running       = (state_q == S_RUNNING);
  assign time_up       = (state_q == S_EXPIRED);
  assign time_up_pulse = pulse_q;
  assign warning       = ((state_q == S_RUNNING) || (state_q == S_PAUSED)) &&
                         (secs_q != '0) && (secs_q <= WARN_S);

`ifndef SYNTHESIS
  a_no_double_pulse: assert property (@(posedge clk_game) disable iff (!reset_n)
    time_up_pulse |=> !time_up_pulse);
  a_secs_max: assert property (@(posedge clk_game) disable iff (!reset_n)
    seconds_left <= MAX_S);
`endif

endmodule

// File: tb/tb_game_countdown_timer.sv
// Scoreboard bench for game_countdown_timer: stimulus pushes hand-computed
// expected outputs tagged with the cycle they must appear; a monitor on the
// falling clock edge pops and compares them.

module tb_game_countdown_timer;

  logic       clk_game = 1'b0;
  logic       reset_n  = 1'b1;
  logic       load = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [7:0] load_value = '0;
`ifdef TIME_BONUS_EN
  logic       bonus = 1'b0;
  logic [3:0] bonus_value = '0;
`endif
  logic [7:0] seconds_left;
  logic [1:0] state;
  logic       running, warning, time_up, time_up_pulse;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [7:0]  secs;
    logic [1:0]  st;
    logic [3:0]  flags; // {running, warning, time_up, time_up_pulse}
  } exp_t;

  exp_t sb[$];

  game_countdown_timer #(
    .TICKS_PER_SEC(60),
    .MAX_SECONDS(99),
    .WARN_SECONDS(10)
  ) dut (
    .clk_game(clk_game),
    .reset_n(reset_n),
    .load(load),
    .load_value(load_value),
    .start(start),
    .pause(pause),
    .abort(abort),
`ifdef TIME_BONUS_EN
    .bonus(bonus),
    .bonus_value(bonus_value),
`endif
    .seconds_left(seconds_left),
    .state(state),
    .running(running),
    .warning(warning),
    .time_up(time_up),
    .time_up_pulse(time_up_pulse)
  );

  always #5 clk_game = ~clk_game;
  always @(posedge clk_game) cyc++;

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clk_game) begin
    exp_t e;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", e.name, e.cyc, cyc);
      end else if (seconds_left !== e.secs || state !== e.st ||
                   {running, warning, time_up, time_up_pulse} !== e.flags) begin
        failures++;
        $display("FAIL %s: got secs=%0d state=%0d flags=%b, expected secs=%0d state=%0d flags=%b",
                 e.name, seconds_left, state, {running, warning, time_up, time_up_pulse},
                 e.secs, e.st, e.flags);
      end
    end
  end

  task automatic expect_now(input string name, input int s, input int st, input logic [3:0] f);
    exp_t e;
    e.cyc = cyc; e.name = name; e.secs = 8'(s); e.st = 2'(st); e.flags = f;
    sb.push_back(e);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk_game);
      #1;
    end
  endtask

  task automatic do_load(input int v);
    load_value = 8'(v); load = 1'b1; step(1); load = 1'b0;
  endtask
  task automatic do_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask
  task automatic do_pause();
    pause = 1'b1; step(1); pause = 1'b0;
  endtask
  task automatic do_abort();
    abort = 1'b1; step(1); abort = 1'b0;
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset_n = 1'b0;
    step(2);
    expect_now("reset", 0, 0, 4'b0000);
    reset_n = 1'b1;
    step(1);

    // Basic countdown 3 -> 0
    do_load(3);         expect_now("load3", 3, 0, 4'b0000);
    do_start();         expect_now("start_run", 3, 1, 4'b1100);
    step(59);           expect_now("t1_59", 3, 1, 4'b1100);
    step(1);            expect_now("t1_dec1", 2, 1, 4'b1100);
    step(59);           expect_now("t1_119", 2, 1, 4'b1100);
    step(1);            expect_now("t1_dec2", 1, 1, 4'b1100);
    step(59);           expect_now("t1_179", 1, 1, 4'b1100);
    step(1);            expect_now("t1_expire", 0, 3, 4'b0011);
    step(1);            expect_now("t1_pulse_once", 0, 3, 4'b0010);
    do_start();         expect_now("t1_start_ignored", 0, 3, 4'b0010);

    // Saturation and zero start
    do_load(200);       expect_now("sat99", 99, 0, 4'b0000);
    do_load(0);         expect_now("load0", 0, 0, 4'b0000);
    do_start();         expect_now("start_zero", 0, 3, 4'b0011);
    step(1);            expect_now("zero_pulse_once", 0, 3, 4'b0010);

    // Pause keeps sub-second progress; warning threshold; expiry
    do_load(12);        expect_now("t3_load", 12, 0, 4'b0000);
    do_start();         expect_now("t3_run", 12, 1, 4'b1000);
    step(30);
    do_pause();         expect_now("t3_paused", 12, 2, 4'b0000);
    step(50);           expect_now("t3_hold50", 12, 2, 4'b0000);
    do_pause();         expect_now("t3_pause_ign", 12, 2, 4'b0000);
    step(49);           expect_now("t3_hold100", 12, 2, 4'b0000);
    do_start();         expect_now("t3_resume", 12, 1, 4'b1000);
    step(29);           expect_now("t3_r29", 12, 1, 4'b1000);
    step(1);            expect_now("t3_r30", 11, 1, 4'b1000);
    step(59);           expect_now("t3_r89", 11, 1, 4'b1000);
    step(1);            expect_now("t3_warn10", 10, 1, 4'b1100);
    step(599);          expect_now("t3_last", 1, 1, 4'b1100);
    step(1);            expect_now("t3_expired", 0, 3, 4'b0011);

    // Idle load never warns, pause ignored in IDLE
    do_load(5);         expect_now("idle5", 5, 0, 4'b0000);
    do_pause();         expect_now("idle_pause_ign", 5, 0, 4'b0000);

    // load beats abort, then abort alone
    do_load(7);
    do_start();         expect_now("t5_run7", 7, 1, 4'b1100);
    step(5);
    load_value = 8'd20; load = 1'b1; abort = 1'b1;
    step(1);
    load = 1'b0; abort = 1'b0;
                        expect_now("load_over_abort", 20, 0, 4'b0000);
    do_abort();         expect_now("abort", 0, 0, 4'b0000);

    // load on the tick-wrap cycle wins with no decrement
    do_load(2);
    do_start();
    step(59);           expect_now("t6_pre_wrap", 2, 1, 4'b1100);
    do_load(4);         expect_now("load_on_wrap", 4, 0, 4'b0000);

    // pause wins over simultaneous start
    do_load(5);
    do_start();
    step(3);
    pause = 1'b1; start = 1'b1;
    step(1);
    pause = 1'b0; start = 1'b0;
                        expect_now("pause_wins", 5, 2, 4'b0100);
    do_start();         expect_now("resume5", 5, 1, 4'b1100);

`ifdef TIME_BONUS_EN
    do_load(97);
    do_start();         expect_now("b_run97", 97, 1, 4'b1000);
    bonus = 1'b1; bonus_value = 4'd5;
    step(1);
    bonus = 1'b0;       expect_now("b_sat99", 99, 1, 4'b1000);
    do_load(1);
    do_start();
    step(59);           expect_now("b_pre_wrap", 1, 1, 4'b1100);
    bonus = 1'b1; bonus_value = 4'd3;
    step(1);
    bonus = 1'b0;       expect_now("b_wrap_bonus", 3, 1, 4'b1100);
    do_load(5);
    bonus = 1'b1; bonus_value = 4'd3;
    step(1);
    bonus = 1'b0;       expect_now("b_idle_ign", 5, 0, 4'b0000);
`endif

    // Asynchronous reset mid-count: observed before any further clock edge
    do_load(9);
    do_start();
    step(10);           expect_now("t8_pre_reset", 9, 1, 4'b1100);
    step(1);
    reset_n = 1'b0;     expect_now("async_reset", 0, 0, 4'b0000);
    step(1);            expect_now("reset_held", 0, 0, 4'b0000);
    reset_n = 1'b1;

    step(2);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
